// File: rtl/vadd_const_pipe_pkg.sv
// Shared types and constants for the per-lane vector add/sub-by-constant pipeline.
package vadd_const_pipe_pkg;

    localparam int MAX_LANES = 8;
    localparam int MAX_WIDTH = 24;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef logic [MAX_WIDTH-1:0] elem_max_t;

    // cfg_lane needs at least one bit even for a single-lane build
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vadd_const_pipe_if.sv
// Stream-in / stream-out handshake plus constant-file write port.
interface vadd_const_pipe_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
);
    localparam int LW = vadd_const_pipe_pkg::lane_idx_w(LANES);

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_sub;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   cfg_we;
    logic [LW-1:0]          cfg_lane;
    logic [WIDTH-1:0]       cfg_data;

    modport master (
        output in_valid, in_data, in_sub, out_ready, cfg_we, cfg_lane, cfg_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sub, out_ready, cfg_we, cfg_lane, cfg_data,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/vadd_const_pipe_lane.sv
// One lane: element +/- constant. VADD_CONST_PIPE_SAT_EN selects unsigned
// saturation instead of modulo-2^WIDTH wrap.
module vadd_lane
    import vadd_const_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] elem_i,
    input  logic [WIDTH-1:0] cnst_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] res_o
);

`ifdef VADD_CONST_PIPE_SAT_EN
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    assign sum = {1'b0, elem_i} + {1'b0, cnst_i};
    assign dif = {1'b0, elem_i} - {1'b0, cnst_i};

    // top bit is carry-out for add, borrow for sub
    always_comb begin
        res_o = sum[WIDTH-1:0];
        if (op_i == OP_SUB) res_o = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
        else if (sum[WIDTH]) res_o = '1;
    end
`else
    assign res_o = (op_i == OP_SUB) ? elem_i - cnst_i : elem_i + cnst_i;
`endif

endmodule

// File: rtl/vadd_const_pipe.sv
// Two-stage SIMD add/sub-by-per-lane-constant pipeline with ready/valid flow control.
// Optional saturation via VADD_CONST_PIPE_SAT_EN (implemented in vadd_lane).
module vadd_const_pipe
    import vadd_const_pipe_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    vadd_const_pipe_if.slave  bus
);

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    vec_t       consts_q;
    vec_t       s1_data_q;
    vec_t       s1_const_q;
    op_e        s1_op_q;
    vec_t       s2_data_q;
    vec_t       s2_data_d;
    vec_t       in_vec;
    logic [2:1] vld_q;
    logic       s2_adv;
    logic       s1_adv;

    assign in_vec = bus.in_data;

    // S2 loads when empty or being drained; S1 loads whenever it can hand off
    assign s2_adv = !vld_q[2] || bus.out_ready;
    assign s1_adv = !vld_q[1] || s2_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = vld_q[2];
    assign bus.out_data  = s2_data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            consts_q <= '0;
        end else if (bus.cfg_we && (int'(bus.cfg_lane) < LANES)) begin
            consts_q[bus.cfg_lane] <= bus.cfg_data;
        end
    end

    // S1 snapshots the constants so later cfg writes never touch in-flight vectors
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q      <= '0;
            s1_data_q  <= '0;
            s1_const_q <= '0;
            s1_op_q    <= OP_ADD;
            s2_data_q  <= '0;
        end else begin
            if (s1_adv) begin
                vld_q[1] <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data_q  <= in_vec;
                    s1_const_q <= consts_q;
                    s1_op_q    <= op_e'(bus.in_sub);
                end
            end
            if (s2_adv) begin
                vld_q[2] <= vld_q[1];
                if (vld_q[1]) s2_data_q <= s2_data_d;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vadd_lane #(.WIDTH(WIDTH)) u_lane (
            .elem_i (s1_data_q[i]),
            .cnst_i (s1_const_q[i]),
            .op_i   (s1_op_q),
            .res_o  (s2_data_d[i])
        );
    end

endmodule

// File: tb/tb_vadd_const_pipe.sv
// Bench for vadd_const_pipe: directed table, corner sequences, random stream vs reference model.
module tb_vadd_const_pipe;

    localparam int L = 4;
    localparam int W = 8;
`ifdef VADD_CONST_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] cst;
        logic [31:0] din;
        logic        sub;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vadd_const_pipe_if #(.LANES(L), .WIDTH(W)) bus ();
    vadd_const_pipe_if #(.LANES(5), .WIDTH(W)) bus5 ();

    vadd_const_pipe #(.LANES(L), .WIDTH(W)) dut (.clock(clk), .reset(rst_n), .bus(bus));
    vadd_const_pipe #(.LANES(5), .WIDTH(W)) dut5 (.clock(clk), .reset(rst_n), .bus(bus5));

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  const_m [L];
    logic [31:0] exp_q [$];
    bit          hold_p = 1'b0;
    logic [31:0] hold_d;
    vec_t        tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: per-lane integer arithmetic, then wrap or clamp to 0..255
    function automatic logic [31:0] ref_vec(input logic [31:0] d, input logic s);
        logic [31:0] res;
        int a, k, r;
        for (int l = 0; l < L; l++) begin
            a = int'(d[l*8 +: 8]);
            k = int'(const_m[l]);
            r = s ? a - k : a + k;
            if (SAT) begin
                if (r < 0)   r = 0;
                if (r > 255) r = 255;
            end else begin
                r = (r + 256) % 256;
            end
            res[l*8 +: 8] = r[7:0];
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", 64'(bus.out_data), 64'(hold_d));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got %0h want none at %0t", bus.out_data, $time);
                end else begin
                    chk("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                    n_out++;
                end
            end
            hold_p = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_vec(bus.in_data, bus.in_sub));
            if (bus.cfg_we && int'(bus.cfg_lane) < L) const_m[bus.cfg_lane] = bus.cfg_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int lane, input logic [7:0] val);
        bus.cfg_we   = 1'b1;
        bus.cfg_lane = 2'(lane);
        bus.cfg_data = val;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg5_wr(input int lane, input logic [7:0] val);
        bus5.cfg_we   = 1'b1;
        bus5.cfg_lane = 3'(lane);
        bus5.cfg_data = val;
        step();
        bus5.cfg_we = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base, got, saw_low;
        bit pend;

        tbl[0] = '{32'hFD05FC02, 32'h10203040, 1'b0, 32'h0D252C42, 32'hFF25FF42};
        tbl[1] = '{32'hFD05FC02, 32'h000000FF, 1'b0, 32'hFD05FC01, 32'hFD05FCFF};
        tbl[2] = '{32'hFD05FC02, 32'h00000001, 1'b1, 32'h03FB04FF, 32'h00000000};
        tbl[3] = '{32'h01020304, 32'h80808080, 1'b1, 32'h7F7E7D7C, 32'h7F7E7D7C};
        tbl[4] = '{32'hFFFFFFFF, 32'h01000100, 1'b0, 32'h00FF00FF, 32'hFFFFFFFF};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_lane = '0; bus.cfg_data = '0;
        bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.in_sub = 1'b0; bus5.out_ready = 1'b1;
        bus5.cfg_we = 1'b0; bus5.cfg_lane = '0; bus5.cfg_data = '0;
        for (int l = 0; l < L; l++) const_m[l] = '0;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        #10 rst_n = 1'b1;
        mon_en = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // out-of-range lane writes on a 5-lane instance are dropped
        cfg5_wr(7, 8'h55);
        cfg5_wr(5, 8'h66);
        cfg5_wr(4, 8'h11);
        bus5.in_valid = 1'b1; bus5.in_data = 40'h0102030405;
        step();
        bus5.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ign_valid", 64'(bus5.out_valid), 64'd1);
        chk("ign_data", 64'(bus5.out_data), 64'h1202030405);
        step();

        for (int i = 0; i < 5; i++) begin
            for (int l = 0; l < L; l++) cfg_wr(l, tbl[i].cst[l*8 +: 8]);
            bus.in_valid = 1'b1; bus.in_data = tbl[i].din; bus.in_sub = tbl[i].sub;
            step();
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_lat1", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
            chk("tbl_valid", 64'(bus.out_valid), 64'd1);
            chk($sformatf("tbl_data[%0d]", i), 64'(bus.out_data),
                64'(SAT ? tbl[i].exp_sat : tbl[i].exp_wrap));
            step();
        end

        // cfg write coincident with accepting A; B follows next cycle
        bus.in_valid = 1'b1; bus.in_data = '0; bus.in_sub = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_lane = 2'd1; bus.cfg_data = 8'h10;
        step();
        bus.cfg_we = 1'b0;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("cfg_old_A", 64'(bus.out_data), 64'hFFFFFFFF);
        @(negedge clk);
        chk("cfg_new_B", 64'(bus.out_data), 64'hFFFF10FF);
        step();

        base = n_out;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1; bus.in_data = $urandom; bus.in_sub = 1'($urandom);
            @(negedge clk);
            chk("stream_rdy", 64'(bus.in_ready), 64'd1);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_cnt_m1", 64'(n_out - base), 64'd15);
        step();
        chk("stream_cnt", 64'(n_out - base), 64'd16);

        got = 0; saw_low = 0;
        for (int c = 0; c < 40 && got < 12; c++) begin
            bus.out_ready = !(c >= 4 && c < 9);
            if (!bus.in_valid) begin
                bus.in_valid = 1'b1; bus.in_data = $urandom; bus.in_sub = 1'($urandom);
            end
            @(negedge clk);
            pend = bus.in_ready;
            if (pend) got++;
            else saw_low++;
            step();
            if (pend) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("bp_got", 64'(got), 64'd12);
        chk("bp_inready_low", 64'(saw_low), 64'd5);
        drain("bp_drain");

        pend = 1'b0;
        for (int c = 0; c < 300; c++) begin
            bus.out_ready = ($urandom_range(3) != 0);
            if (!pend) begin
                bus.in_valid = ($urandom_range(2) != 0);
                bus.in_data  = $urandom;
                bus.in_sub   = 1'($urandom);
            end
            bus.cfg_we   = ($urandom_range(7) == 0);
            bus.cfg_lane = 2'($urandom_range(3));
            bus.cfg_data = 8'($urandom);
            @(negedge clk);
            pend = bus.in_valid && !bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0; bus.out_ready = 1'b1;
        drain("rand_drain");

        // asynchronous reset with two vectors in flight
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'hAABBCCDD;
        step();
        bus.in_data = 32'h11111111;
        step();
        bus.in_valid = 1'b0;
        #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_out_data", 64'(bus.out_data), 64'd0);
        exp_q.delete();
        for (int l = 0; l < L; l++) const_m[l] = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("arst_nostale0", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("arst_nostale1", 64'(bus.out_valid), 64'd0);
        step();
        mon_en = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'h11223344; bus.in_sub = 1'b0;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_const_zero", 64'(bus.out_data), 64'h11223344);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
